// File: rtl/piso_shift_reg_pkg.sv
// Shared definitions for the parallel-in / serial-out shift register and its
// serial-in counterparts, so both ends agree on word width and state encoding.
package piso_shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/piso_shift_reg_bit_counter.sv
// Down-counter for the bits remaining in the current word: loads WIDTH-1,
// decrements on request and holds at zero instead of wrapping.
module bit_counter
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WIDTH - 1);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with a load handshake and framing
// flags; back-to-back words stream with no idle cycle between them.
module piso_shift_reg
  import piso_shift_reg_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Dout,
  output logic             Valid,
  output logic             Last,
  output state_t           dbg_state
);

  // Handshake: a word is taken on a rising edge where Load && Ready; Ready
  // depends only on registered state, and Valid marks every cycle in which
  // Dout carries a data bit (Last flags the final bit of a word).
  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic             cnt_zero;
  logic             load_fire;
  logic             shift_en;

  assign load_fire = Load && Ready;
  assign shift_en  = (state_q == ST_SHIFT) && !cnt_zero;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (load_fire),
    .dec   (shift_en),
    .zero  (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (Load) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_zero && !Load) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sr_q <= '0;
    end else if (load_fire) begin
      sr_q <= Din;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_q <= {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    Ready = 1'b1;
    Valid = 1'b0;
    Last  = 1'b0;
    Dout  = 1'b0;
    if (state_q == ST_SHIFT) begin
      Ready = cnt_zero;
      Valid = 1'b1;
      Last  = cnt_zero;
      Dout  = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    end
  end

  assign dbg_state = state_q;

endmodule
